// File: rtl/uart_text_console.sv
// Character terminal front end: pops received bytes and writes glyph codes
// into the text video memory, tracking a cursor over a 64x48 grid.
module uart_text_console #(
  parameter int          COLS  = 64,
  parameter int          ROWS  = 48,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        mem_ready,
  input  logic        clear_req,
  output logic [11:0] w_addr,
  output logic [7:0]  w_data,
  output logic        w_valid,
  output logic [5:0]  cursor_row,
  output logic [5:0]  cursor_col,
  output logic        busy,
  output logic [15:0] char_count
);

  typedef enum logic [2:0] {
    INIT, IDLE, FETCH, EXEC, CLR_LINE, CLR_SCREEN
  } state_t;

  localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [11:0] LAST_ADDR = 12'(ROWS * COLS - 1);

  state_t      state, state_n;
  logic [7:0]  rx_byte, rx_byte_n;
  logic        pend, pend_n;
  logic [5:0]  row_n, col_n, row_adv;
  logic [11:0] w_addr_n;
  logic [7:0]  w_data_n;
  logic        w_valid_n;
  logic [15:0] count_n;

  function automatic logic printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  always_comb begin
    row_adv   = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
    state_n   = state;
    rx_byte_n = rx_byte;
    pend_n    = pend | clear_req;
    row_n     = cursor_row;
    col_n     = cursor_col;
    w_addr_n  = w_addr;
    w_data_n  = w_data;
    w_valid_n = 1'b0;
    count_n   = char_count;
    unique case (state)
      INIT: if (mem_ready) state_n = CLR_SCREEN;
      IDLE: begin
        if (pend) state_n = CLR_SCREEN;
        else if (rx_valid) state_n = FETCH;
      end
      FETCH: begin
        rx_byte_n = rx_data;
        state_n   = EXEC;
        // write is issued from the raw byte so it lands in the EXEC cycle
        if (printable(rx_data)) begin
          w_valid_n = 1'b1;
          w_addr_n  = {cursor_row, cursor_col};
          w_data_n  = rx_data;
        end else if (rx_data == 8'h08 && cursor_col != 6'd0) begin
          w_valid_n = 1'b1;
          w_addr_n  = {cursor_row, cursor_col - 6'd1};
          w_data_n  = BLANK;
        end
      end
      EXEC: begin
        state_n = IDLE;
        unique case (1'b1)
          printable(rx_byte): begin
            count_n = char_count + 16'd1;
            if (cursor_col != LAST_COL) begin
              col_n = cursor_col + 6'd1;
            end else begin
              col_n   = 6'd0;
              row_n   = row_adv;
              state_n = CLR_LINE;
            end
          end
          rx_byte == 8'h0A: begin
            col_n   = 6'd0;
            row_n   = row_adv;
            state_n = CLR_LINE;
          end
          rx_byte == 8'h0D: col_n = 6'd0;
          rx_byte == 8'h08: begin
            if (cursor_col != 6'd0) col_n = cursor_col - 6'd1;
          end
          rx_byte == 8'h0C: state_n = CLR_SCREEN;
          default: ;
        endcase
      end
      CLR_LINE: begin
        if (w_addr[5:0] == LAST_COL) begin
          state_n = IDLE;
        end else begin
          w_valid_n = 1'b1;
          w_addr_n  = w_addr + 12'd1;
        end
      end
      CLR_SCREEN: begin
        if (w_addr == LAST_ADDR) begin
          state_n = IDLE;
          row_n   = 6'd0;
          col_n   = 6'd0;
          pend_n  = 1'b0;
        end else begin
          w_valid_n = 1'b1;
          w_addr_n  = w_addr + 12'd1;
        end
      end
      default: state_n = INIT;
    endcase
    if (state_n == CLR_LINE && state != CLR_LINE)
      {w_valid_n, w_addr_n, w_data_n} = {1'b1, row_n, 6'd0, BLANK};
    if (state_n == CLR_SCREEN && state != CLR_SCREEN)
      {w_valid_n, w_addr_n, w_data_n} = {1'b1, 12'd0, BLANK};
    if (!mem_ready) begin
      state_n   = INIT;
      w_valid_n = 1'b0;
      row_n     = 6'd0;
      col_n     = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      rx_byte    <= 8'd0;
      pend       <= 1'b0;
      rx_rd      <= 1'b0;
      w_addr     <= 12'd0;
      w_data     <= 8'd0;
      w_valid    <= 1'b0;
      cursor_row <= 6'd0;
      cursor_col <= 6'd0;
      busy       <= 1'b0;
      char_count <= 16'd0;
    end else begin
      state      <= state_n;
      rx_byte    <= rx_byte_n;
      pend       <= pend_n;
      rx_rd      <= (state_n == FETCH);
      w_addr     <= w_addr_n;
      w_data     <= w_data_n;
      w_valid    <= w_valid_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      busy       <= (state_n != IDLE);
      char_count <= count_n;
    end
  end

endmodule

// File: tb/tb_uart_text_console.sv
// Directed bench for uart_text_console: a cursor model pushes expected
// writes to a queue, a negedge monitor pops and compares them.
module tb_uart_text_console;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        mem_ready;
  logic        clear_req;
  logic [11:0] w_addr;
  logic [7:0]  w_data;
  logic        w_valid;
  logic [5:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic        busy;
  logic [15:0] char_count;

  uart_text_console dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_rd      (rx_rd),
    .mem_ready  (mem_ready),
    .clear_req  (clear_req),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy),
    .char_count (char_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  logic [19:0] q[$];
  logic [5:0]  mrow, mcol;
  logic [15:0] mcount;

  always @(negedge clk) begin
    logic [19:0] e;
    if (rx_rd) rd_cnt++;
    if (w_valid) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write got %03h/%02h exp none", w_addr, w_data);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert ({w_addr, w_data} === e) else begin
          errors++;
          $error("FAIL write got %03h/%02h exp %03h/%02h",
                 w_addr, w_data, e[19:8], e[7:0]);
        end
      end
      checks++;
      assert (busy === 1'b1) else begin
        errors++;
        $error("FAIL busy_on_write got %b exp 1", busy);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_line();
    for (int c = 0; c < 64; c++) q.push_back({mrow, 6'(c), 8'h20});
  endtask

  task automatic push_screen();
    for (int a = 0; a < 3072; a++) q.push_back({12'(a), 8'h20});
    mrow = 6'd0;
    mcol = 6'd0;
  endtask

  task automatic adv();
    mrow = (mrow == 6'd47) ? 6'd0 : mrow + 6'd1;
  endtask

  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      q.push_back({mrow, mcol, b});
      mcount++;
      if (mcol < 6'd63) mcol++;
      else begin mcol = 6'd0; adv(); push_line(); end
    end else if (b == 8'h0A) begin
      mcol = 6'd0; adv(); push_line();
    end else if (b == 8'h0D) begin
      mcol = 6'd0;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin mcol--; q.push_back({mrow, mcol, 8'h20}); end
    end else if (b == 8'h0C) begin
      push_screen();
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < budget);
    chk("idle_timeout", busy, 0);
    chk("sb_empty", q.size(), 0);
  endtask

  task automatic wait_rd();
    int n = 0;
    do begin @(negedge clk); n++; end while (!rx_rd && n < 50);
    chk("rd_timeout", rx_rd, 1);
  endtask

  task automatic send(input logic [7:0] b);
    model(b);
    rx_data  = b;
    rx_valid = 1'b1;
    wait_rd();
    rx_valid = 1'b0;
    wait_idle(4000);
    chk("cursor", {cursor_row, cursor_col}, {mrow, mcol});
    chk("char_count", char_count, mcount);
  endtask

  initial begin
    int rd0, n;
    reset_n = 1'b0; mem_ready = 1'b0; clear_req = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    mrow = 6'd0; mcol = 6'd0; mcount = 16'd0;
    #3;
    chk("reset_outs", {rx_rd, w_addr, w_data, w_valid, cursor_row,
                       cursor_col, busy, char_count}, 64'd0);
    #9 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("init_busy", busy, 1);
    chk("init_wvalid", w_valid, 0);
    push_screen();
    mem_ready = 1'b1;
    wait_idle(4000);
    chk("init_cursor", {cursor_row, cursor_col}, 12'd0);

    rd0 = rd_cnt;
    send("H");
    send("i");
    chk("hi_cursor", {cursor_row, cursor_col}, {6'd0, 6'd2});
    chk("hi_count", char_count, 16'd2);
    chk("hi_rd_pulses", rd_cnt - rd0, 2);

    for (int i = 0; i < 61; i++) send(8'h61 + 8'(i % 26));
    chk("col63", cursor_col, 6'd63);
    send("A");
    chk("wrap_cursor", {cursor_row, cursor_col}, {6'd1, 6'd0});

    for (int i = 0; i < 46; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send("k");
    chk("at_47_5", {cursor_row, cursor_col}, {6'd47, 6'd5});
    send(8'h0A);
    chk("row_wrap", {cursor_row, cursor_col}, 12'd0);
    send(8'h08);
    send("x");
    send(8'h08);
    chk("bs_cursor", {cursor_row, cursor_col}, 12'd0);
    send("m");
    send(8'h07);
    send(8'h0D);
    chk("cr_cursor", cursor_col, 6'd0);

    model("Q");
    push_screen();
    rx_data = "Q";
    rx_valid = 1'b1;
    wait_rd();
    rx_valid = 1'b0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 4000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("fc_busy", busy, 0);
    chk("fc_sb_empty", q.size(), 0);
    chk("fc_cursor", {cursor_row, cursor_col}, 12'd0);
    chk("fc_count", char_count, mcount);

    model(8'h0A);
    rx_data = 8'h0A;
    rx_valid = 1'b1;
    wait_rd();
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("in_clr_line", w_valid, 1);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("loss_wvalid", w_valid, 0);
    chk("loss_busy", busy, 1);
    chk("loss_cursor", {cursor_row, cursor_col}, 12'd0);
    q.delete();
    mrow = 6'd0; mcol = 6'd0;

    push_screen();
    mem_ready = 1'b1;
    repeat (100) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst", {rx_rd, w_addr, w_data, w_valid, cursor_row,
                      cursor_col, busy, char_count}, 64'd0);
    q.delete();
    mcount = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    push_screen();
    wait_idle(4000);
    send("Z");
    chk("post_rst_count", char_count, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_text_console.md
# uart_text_console

Character-terminal front end for the text video path. Consumes received bytes from the `serial_top` receive buffer, interprets printable characters and a small set of control codes, and writes character codes into `video_memory` through its write port (`w_addr`/`w_data`/`w_valid`), where the `text_rom` lookup renders them. It tracks a cursor over a 64-column by 48-row text grid. Entering a new row always blanks it first, so output wraps top-to-bottom without scrolling.

## Interface
Parameters:
- `COLS`, 64: text columns per row; must be 64, which fixes the address split below.
- `ROWS`, 48: visible text rows (768 / 16).
- `BLANK`, 8'h20: character code used when clearing.

Ports:
- `clk`  in  1  system clock (65 MHz in the SVGA build).
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  receive byte available; connect to `bufr_full`.
- `rx_data`  in  8  received byte; connect to `rx_rdata`.
- `rx_rd`  out  1  one-clock pulse that pops the receive buffer; connect to `rd_rdata`.
- `mem_ready`  in  1  video memory initialised; connect to `reset_done`.
- `clear_req`  in  1  single-cycle request to clear the whole screen.
- `w_addr`  out  12  video memory address {row[5:0], col[5:0]}.
- `w_data`  out  8  character code to write.
- `w_valid`  out  1  write strobe, one word per cycle.
- `cursor_row`  out  6  current cursor row.
- `cursor_col`  out  6  current cursor column.
- `busy`  out  1  high in every state except IDLE.
- `char_count`  out  16  number of printed characters, wraps modulo 2^16.

## Operation
States: INIT, IDLE, FETCH, EXEC, CLR_LINE, CLR_SCREEN.

- **Reset.** Reset forces state INIT. All outputs go to 0, including the cursor at (0,0) and `char_count`, and the pending-clear flag is cleared.
- **INIT.** Stays in INIT while `mem_ready`=0. When `mem_ready`=1, moves to CLR_SCREEN.
- **Loss of `mem_ready`.** If `mem_ready` drops in any state, the next state is INIT, `w_valid` goes to 0 next cycle, and the cursor resets to (0,0).
- **IDLE priorities.**
  - First: a pending clear (latched `clear_req`) goes to CLR_SCREEN.
  - Otherwise, `rx_valid`=1 goes to FETCH.
- **clear_req outside IDLE.** Sets the pending flag. It is serviced at the next IDLE and is never lost. Multiple requests merge into one clear.
- **FETCH.** `rx_rd`=1 for this one cycle; `rx_data` is captured at the end of the cycle. Next state is EXEC.
- **EXEC.** Decodes the captured byte:
  - 0x20–0x7E: write the byte at {row,col}; `char_count`+1.
    - If col<COLS-1: col+1, back to IDLE.
    - Else: col=0, row advances, go to CLR_LINE.
  - 0x0A (LF): col=0, row advances, go to CLR_LINE.
  - 0x0D (CR): col=0, back to IDLE.
  - 0x08 (BS): if col>0, col-1 and write BLANK at the new column; if col=0, no change. Back to IDLE.
  - 0x0C (FF): go to CLR_SCREEN.
  - Any other byte is consumed and ignored, then back to IDLE.
- **Row advance.** row+1, wrapping ROWS-1 to 0.
- **CLR_LINE.** Writes BLANK to {row, 0..COLS-1}, one per cycle, in 64 cycles, then returns to IDLE. The cursor stays at (row, 0).
- **CLR_SCREEN.**
  - Writes BLANK to addresses 0 through ROWS*64-1 in ascending order, 3072 cycles total.
  - Then sets the cursor to (0,0), clears the pending flag, and returns to IDLE.
  - `char_count` is not reset by a clear.
- **Address bounds.** Rows 48–63 are never addressed.

## Timing
- All outputs are registered.
- Single byte, cycle by cycle (IDLE samples `rx_valid`=1 at edge T):
  - Cycle T+1: `rx_rd`=1.
  - Cycle T+2: `w_valid`=1 with the address and data of the captured byte.
  - Cursor outputs update at the edge ending cycle T+2.
  - IDLE again at T+3.
  - Minimum is 3 cycles per simple character.
- `rx_valid` is sampled only in IDLE. The receive buffer must drop `bufr_full` within 2 cycles of `rx_rd`; `serial_top` does.
- Line wrap costs 64 extra write cycles. A full clear costs 3072 cycles.
- Under back-to-back bytes, `w_valid` is never high for two consecutive cycles except during CLR_LINE or CLR_SCREEN.
- `w_addr` and `w_data` are held at their last value when `w_valid`=0.
- Async reset assertion mid-clear aborts immediately. After reset, the full INIT then CLR_SCREEN sequence reruns.

## Test plan
- **Reset and init clear.** Reset, then `mem_ready`=1 at cycle 10 → exactly 3072 writes of 0x20 to addresses 0x000–0xBFF with `busy`=1, then IDLE with the cursor at (0,0).
- **Print sequence.** Send "Hi" → writes (0x000, 0x48) and (0x001, 0x69). Cursor ends at (0,2), `char_count`=2, and there is exactly one `rx_rd` pulse per byte.
- **Auto-wrap.** Cursor at (0,63), send 'A' → write (0x03F, 0x41), then 64 writes of 0x20 to 0x040–0x07F. Cursor ends at (1,0).
- **Row wrap and backspace.** Cursor at (47,5), send LF → cursor (0,0) and row 0 blanked (addresses 0x000–0x03F). Then BS at col 0 → no write. Then 'x', BS → write 0x78 at 0x000, then 0x20 at 0x000; cursor (0,0).
- **Clear request during fetch.** Pulse `clear_req` while in FETCH → the current byte completes first, then CLR_SCREEN runs once.
- **Memory loss and reset.** Drop `mem_ready` during CLR_LINE → `w_valid`=0 the next cycle and state is INIT with cursor (0,0). Then assert `reset_n`=0 mid-CLR_SCREEN → all outputs 0 asynchronously.
